// File: rtl/uart_rx_holding.sv
// 8N1 UART receiver (LSB first) with a one-byte holding register and sticky error flags.
// rx_valid rises 2+H+9*CLKS_PER_BIT+1 cycles after the start edge; it holds until rx_rd_strobe, and unread bytes set overrun.
module uart_rx_holding #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_rd_strobe,
  output logic       framing_err,
  output logic       overrun
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          framing_err_q, framing_err_d;
  logic          overrun_q, overrun_d;

  logic rx_s;
  logic complete;
  logic frame_bad;

  assign rx_s = sync2_q;

  // Frame FSM: every sample point is measured from the first low cycle seen in IDLE.
  always_comb begin
    sync1_d   = rx_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    complete  = 1'b0;
    frame_bad = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rx_s) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rx_s) begin
            complete = 1'b1;
          end else begin
            // Disarm so a held-low (break) line cannot start a phantom frame.
            frame_bad = 1'b1;
            armed_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Holding register: a same-cycle strobe frees the slot for the incoming byte.
  always_comb begin
    rx_data_d     = rx_data_q;
    rx_valid_d    = rx_valid_q;
    framing_err_d = framing_err_q;
    overrun_d     = overrun_q;

    if (rx_rd_strobe) begin
      framing_err_d = 1'b0;
      overrun_d     = 1'b0;
      if (!complete) begin
        rx_valid_d = 1'b0;
      end
    end

    if (complete) begin
      if (!rx_valid_q || rx_rd_strobe) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    if (frame_bad) begin
      framing_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      armed_q       <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_valid_q    <= 1'b0;
      framing_err_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      framing_err_q <= framing_err_d;
      overrun_q     <= overrun_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = framing_err_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_uart_rx_holding.sv
// Bench for uart_rx_holding: two instances (16 and 217 clocks per bit) share the serial line,
// reset and strobe; expected bytes go into a queue when a frame is sent and are popped on rx_valid.
module tb_uart_rx_holding;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_in = 1'b1;
  logic       rx_rd_strobe = 1'b0;
  logic       sel = 1'b0;

  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b, ferr_a, ferr_b, ovr_a, ovr_b;
  logic [7:0] o_data;
  logic       o_valid, o_ferr, o_ovr;

  int         cyc = 0;
  int         t_fall = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];

  uart_rx_holding #(.CLKS_PER_BIT(16)) dut_a (
    .clk(clk), .reset(reset), .rx_in(rx_in),
    .rx_data(data_a), .rx_valid(valid_a), .rx_rd_strobe(rx_rd_strobe),
    .framing_err(ferr_a), .overrun(ovr_a)
  );

  uart_rx_holding #(.CLKS_PER_BIT(217)) dut_b (
    .clk(clk), .reset(reset), .rx_in(rx_in),
    .rx_data(data_b), .rx_valid(valid_b), .rx_rd_strobe(rx_rd_strobe),
    .framing_err(ferr_b), .overrun(ovr_b)
  );

  assign o_data  = sel ? data_b  : data_a;
  assign o_valid = sel ? valid_b : valid_a;
  assign o_ferr  = sel ? ferr_b  : ferr_a;
  assign o_ovr   = sel ? ovr_b   : ovr_a;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop_bit, input bit push);
    if (push) exp_q.push_back(b);
    rx_in  = 1'b0;
    t_fall = cyc;
    repeat (cpb) tick();
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (cpb) tick();
    end
    rx_in = stop_bit;
    repeat (cpb) tick();
  endtask

  task automatic wait_valid(input int budget, output bit ok, output int lat);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (o_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    lat = cyc - t_fall;
  endtask

  task automatic strobe_pulse();
    rx_rd_strobe = 1'b1;
    tick();
    rx_rd_strobe = 1'b0;
  endtask

  task automatic pop_exp(output logic [7:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 8'hxx;
  endtask

  task automatic test_reset();
    sel   = 1'b0;
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    n_tests++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_tests++; if (o_ferr !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", o_ferr); end
    n_tests++; if (o_ovr !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", o_ovr); end
    repeat (4) tick();
  endtask

  task automatic test_single_frame(input bit use_b, input logic [7:0] b, input string name);
    int cpb, exp_lat, lat;
    bit ok;
    logic [7:0] e;
    sel     = use_b;
    cpb     = use_b ? 217 : 16;
    exp_lat = 2 + cpb / 2 + 9 * cpb + 1;
    fork
      send_byte(b, cpb, 1'b1, 1'b1);
      begin
        wait_valid(exp_lat + 40, ok, lat);
        pop_exp(e);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL %s_timeout: rx_valid never rose within %0d cycles", name, exp_lat + 40); end
        n_tests++; if (lat !== exp_lat) begin n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat); end
        n_tests++; if (o_data !== e) begin n_fail++; $display("FAIL %s_data: got %h expected %h", name, o_data, e); end
        n_tests++; if ({o_ferr, o_ovr} !== 2'b00) begin n_fail++; $display("FAIL %s_flags: got %b expected 00", name, {o_ferr, o_ovr}); end
        strobe_pulse();
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL %s_consumed: rx_valid got %b expected 0", name, o_valid); end
      end
    join
    repeat (4) tick();
  endtask

  task automatic test_glitch();
    bit seen;
    sel   = 1'b0;
    seen  = 1'b0;
    rx_in = 1'b0;
    repeat (5) tick();
    rx_in = 1'b1;
    repeat (48) begin
      tick();
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_no_valid: rx_valid got 1 expected 0"); end
    test_single_frame(1'b0, 8'h3C, "glitch_follow");
  endtask

  task automatic test_overrun();
    logic [7:0] e;
    sel = 1'b0;
    send_byte(8'h11, 16, 1'b1, 1'b1);
    send_byte(8'h22, 16, 1'b1, 1'b0);
    tick();
    pop_exp(e);
    n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", o_valid); end
    n_tests++; if (o_data !== e) begin n_fail++; $display("FAIL ovr_data: got %h expected %h", o_data, e); end
    n_tests++; if (o_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", o_ovr); end
    strobe_pulse();
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_clr_valid: got %b expected 0", o_valid); end
    n_tests++; if (o_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr_flag: got %b expected 0", o_ovr); end
    repeat (4) tick();
  endtask

  task automatic test_break();
    bit seen, ok;
    int lat;
    logic [7:0] e;
    sel  = 1'b0;
    seen = 1'b0;
    send_byte(8'h55, 16, 1'b0, 1'b0);
    repeat (40 * 16) begin
      tick();
      if (o_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL break_no_frames: rx_valid got 1 expected 0"); end
    n_tests++; if (o_ferr !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b expected 1", o_ferr); end
    rx_in = 1'b1;
    repeat (32) tick();
    fork
      send_byte(8'h0F, 16, 1'b1, 1'b1);
      begin
        wait_valid(200, ok, lat);
        pop_exp(e);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL break_recover_timeout: rx_valid never rose"); end
        n_tests++; if (o_data !== e) begin n_fail++; $display("FAIL break_recover_data: got %h expected %h", o_data, e); end
        n_tests++; if (o_ferr !== 1'b1) begin n_fail++; $display("FAIL break_ferr_sticky: got %b expected 1", o_ferr); end
        strobe_pulse();
        n_tests++; if (o_ferr !== 1'b0) begin n_fail++; $display("FAIL break_ferr_clr: got %b expected 0", o_ferr); end
      end
    join
    repeat (4) tick();
  endtask

  task automatic test_back_to_back();
    int strobe_at;
    logic [7:0] e;
    sel       = 1'b0;
    strobe_at = 2 + 8 + 9 * 16;
    send_byte(8'h81, 16, 1'b1, 1'b1);
    pop_exp(e);
    n_tests++; if (o_data !== e) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", o_data, e); end
    exp_q.push_back(8'h7E);
    fork
      send_byte(8'h7E, 16, 1'b1, 1'b0);
      begin
        repeat (strobe_at) tick();
        strobe_pulse();
        pop_exp(e);
        n_tests++; if (o_data !== e) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", o_data, e); end
        n_tests++; if (o_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", o_valid); end
        n_tests++; if (o_ovr !== 1'b0) begin n_fail++; $display("FAIL b2b_ovr: got %b expected 0", o_ovr); end
      end
    join
    strobe_pulse();
    n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", o_valid); end
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_frame();
    sel = 1'b0;
    send_byte(8'h99, 16, 1'b1, 1'b0);
    send_byte(8'h44, 16, 1'b1, 1'b0);
    fork
      send_byte(8'hFF, 16, 1'b1, 1'b0);
      begin
        // Land in the middle of data bit 4.
        repeat (16 * 5 + 8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (o_data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", o_data); end
        n_tests++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b expected 0", o_valid); end
        n_tests++; if ({o_ferr, o_ovr} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags: got %b expected 00", {o_ferr, o_ovr}); end
      end
    join
    repeat (8) tick();
    test_single_frame(1'b0, 8'hC3, "midrst_next");
  endtask

  task automatic test_slow_baud();
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (8) tick();
    test_single_frame(1'b1, 8'h00, "slow_00");
    test_single_frame(1'b1, 8'hFF, "slow_ff");
  endtask

  initial begin
    test_reset();
    test_single_frame(1'b0, 8'hA5, "basic_a5");
    test_glitch();
    test_overrun();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    test_slow_baud();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
